// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder/subtractor.
// A single full-adder slice is reused over WIDTH cycles, LSB first.
// Subtraction is a + ~b + 1: the operand is inverted and the carry is preset to 1.
// The result is delivered with a one-cycle done pulse and held until the next completion.
module serial_add_ctrl #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-2:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_accept;
    logic             w_last;
    logic             w_bit;
    logic             w_carry;

    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

    // Start is only honoured when not running (IDLE or DONE).
    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_state == RUN) && (r_cnt == LAST_BIT);
    assign w_bit    = fa_sum(r_opa[0], r_opb[0], r_carry);
    assign w_carry  = fa_carry(r_opa[0], r_opb[0], r_carry);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = (r_cnt == LAST_BIT) ? DONE : RUN;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        busy  = (r_state == RUN);
        ready = (r_state != RUN);
        done  = (r_state == DONE);
    end

    // Operand and partial-result shift registers; contents are don't-care outside RUN.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_opa <= a;
            r_opb <= sub ? ~b : b;
            r_res <= '0;
        end else if (r_state == RUN) begin
            r_opa <= {1'b0, r_opa[WIDTH-1:1]};
            r_opb <= {1'b0, r_opb[WIDTH-1:1]};
            r_res <= {w_bit, r_res[WIDTH-2:1]};
        end
    end

    // Carry, bit counter and the held result; the result only moves on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_carry <= sub;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_carry <= w_carry;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= {w_bit, r_res};
                r_cout <= w_carry;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 12, operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a new operation; sampled only when accepted (REQ-009).
REQ-005 sub  input  1  0 = add, 1 = subtract (a - b); captured with operands.
REQ-006 a  input  WIDTH  operand A; captured on accepted start.
REQ-007 b  input  WIDTH  operand B; captured on accepted start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 ready  output  1  high in IDLE and DONE; start is accepted only when ready=1.
REQ-010 done  output  1  single-cycle pulse marking that the result is valid.
REQ-011 sum  output  WIDTH  registered result, held until the next completion.
REQ-012 cout  output  1  registered final carry; for subtract, 1 = no borrow.

Function
REQ-013 Datapath SHALL be a single 1-bit full-adder slice reused over WIDTH cycles, LSB first; no WIDTH-bit adder is instantiated.
REQ-014 FSM states SHALL be IDLE, RUN and DONE, with encoding free.
REQ-015 Transitions SHALL be: IDLE->RUN on start; RUN->DONE when bit counter = WIDTH-1; DONE->RUN on start; DONE->IDLE otherwise.
REQ-016 On accepted start, the block SHALL load opA<=a, opB<=(sub ? ~b : b), carry<=sub, counter<=0, and clear the internal result shift register.
REQ-017 Each RUN cycle SHALL compute s=opA[0]^opB[0]^carry and carry<=maj(opA[0],opB[0],carry), shift opA/opB right by one, shift s into the result register MSB, and increment the counter.
REQ-018 Latency: with start sampled at edge k, bits 0..WIDTH-1 SHALL be processed at edges k+1..k+WIDTH, and sum/cout/done SHALL update at edge k+WIDTH (k+12 for default).
REQ-019 sum and cout SHALL change only at the completion edge and hold their value during RUN and IDLE.
REQ-020 done SHALL be high for exactly one cycle, the DONE state cycle.
REQ-021 busy SHALL equal (state==RUN), and ready SHALL equal !busy.
REQ-022 start while busy SHALL be ignored; operands and sub changes during RUN SHALL NOT affect the result.
REQ-023 start held high continuously SHALL yield back-to-back operations, each occupying WIDTH+1 cycles (RUN×WIDTH + DONE×1).
REQ-024 Arithmetic SHALL be modulo 2^WIDTH: {cout,sum} = a + b for add, and a + ~b + 1 for subtract.

Reset
REQ-025 rst=1 at an edge SHALL force state=IDLE, busy=0, ready=1, done=0, sum=0, cout=0, counter=0 and carry=0, overriding start.
REQ-026 rst asserted mid-RUN SHALL abort the operation, produce no done pulse, and leave sum=0.
REQ-027 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-028 add a=0x123, b=0x456 -> done exactly 12 edges after start, sum=0x579, cout=0.
REQ-029 add a=0xFFF, b=0x001 -> sum=0x000, cout=1; sub a=0x100, b=0x001 -> sum=0x0FF, cout=1; sub a=0x001, b=0x002 -> sum=0xFFF, cout=0.
REQ-030 start pulsed at RUN cycle 5 with different operands -> ignored; original result delivered and only one done pulse.
REQ-031 start held high for 3 operations -> done pulses 13 cycles apart and each sum is correct.
REQ-032 rst asserted at RUN cycle 7 -> IDLE next cycle, no done, sum=0, cout=0; a subsequent op completes correctly.
REQ-033 Random regression of 10k operations with mixed sub -> {cout,sum} matches the reference model; busy/ready/done satisfy REQ-020/021 every cycle.
